cpu_bus_master: RTL and testbench
=================================

# cpu_bus_master

Synchronous 68030-style bus initiator. It turns a simple one-shot request interface into a complete AS20/DS20/RW20/SIZ bus cycle, terminated by STERM (synchronous), DTACK (asynchronous) or BERR. It is used for card-side DMA and self-test access to fastram, the SPI port, autoconfig and Gayle. It drives the same bus the card's responders decode.

## Interface
Parameters:
- TIMEOUT, 255: WAIT-state cycles before a forced error termination. 0 disables the timeout; legal range 0-255.

Ports:
- CLKCPU  in  1  bus clock; all state is updated on the rising edge.
- RESET  in  1  synchronous reset, active-low.
- REQ  in  1  start a cycle; sampled only in IDLE.
- WE  in  1  1 = write, 0 = read; captured with REQ.
- ADDR  in  32  byte address; captured with REQ.
- SIZE  in  2  030 encoding: 00 long, 01 byte, 10 word, 11 three-byte; captured with REQ.
- WDATA  in  32  write data; captured with REQ.
- RDATA  out  32  read data; valid while ACK=1 and held until the next read completes.
- ACK  out  1  one-cycle completion pulse.
- ERR  out  1  qualifies ACK: BERR or timeout termination.
- BUSY  out  1  high from REQ acceptance until ACK.
- A  out  32  bus address.
- SIZ  out  2  bus size.
- RW20  out  1  1 = read.
- AS20  out  1  address strobe, active-low.
- DS20  out  1  data strobe, active-low.
- D_OUT  out  32  write data to the pad driver.
- D_OE  out  1  data pad enable.
- D_IN  in  32  data from the pads.
- STERM  in  1  synchronous termination, active-low.
- DTACK  in  1  asynchronous termination, active-low.
- BERR  in  1  bus error, active-low.

## Operation
- All outputs are registered. Reset values: A=0, SIZ=00, RW20=1, AS20=1, DS20=1, D_OUT=0, D_OE=0, RDATA=0, ACK=0, ERR=0, BUSY=0. The timeout counter resets to 0. The state resets to IDLE.
- Reset low on any edge, including mid-cycle: the next edge forces the reset values. No ACK is produced for the aborted cycle.

State machine:
- IDLE: when REQ=1, capture ADDR/SIZE/WE/WDATA, load A/SIZ/RW20=~WE, set BUSY=1 and go to ADDR. When REQ=0, stay in IDLE.
- ADDR: AS20=1, DS20=1. On a write, D_OUT=WDATA and D_OE=1. Next state is STROBE.
- STROBE: AS20=0. DS20=0 on a read, DS20=1 on a write. Clear the counter. Next state is WAIT.
- WAIT: AS20=0, DS20=0. Termination inputs are sampled every edge, in this priority:
  - BERR=0: ERR=1, go to END.
  - STERM=0: RDATA<=D_IN on a read, go to END.
  - DTACK=0: go to DLATCH.
  - Counter==TIMEOUT and TIMEOUT!=0: ERR=1, go to END.
  - Otherwise: increment the counter (8-bit, saturating at 255) and stay in WAIT.
- DLATCH: one synchronising cycle with the strobes still asserted. RDATA<=D_IN on a read. Go to END.
- END: AS20=1, DS20=1, ACK=1. ERR holds its value from WAIT. D_OE stays 1 for writes as data hold. Next state is IDLE.
- IDLE entry: ACK=0, ERR=0, BUSY=0, D_OE=0.
- Termination inputs are ignored outside WAIT.
- REQ is ignored outside IDLE.
- On an error termination, RDATA is left unchanged.
- A/SIZ/RW20 stay stable from ADDR through END. They keep their last value in IDLE.

## Timing
- Read or write terminated by STERM in the first WAIT cycle, with REQ sampled at edge k:
  - edge k+1: ADDR
  - edge k+2: STROBE
  - edge k+3: WAIT samples STERM
  - ACK is high after edge k+4 (END)
  - edge k+5: IDLE
- Each extra WAIT cycle adds 1. DTACK termination adds 1 (DLATCH).
- Back-to-back requests: AS20 is high for at least two cycles between cycles (END and ADDR). REQ held high starts the next cycle on the edge after END.
- Write DS20 falls one cycle after AS20. Read DS20 falls together with AS20.
- Timeout with TIMEOUT=N: END follows after N+1 WAIT edges.

## Test plan
- Read, STERM low in the first WAIT, D_IN=0xDEADBEEF, ADDR=0x00200004, SIZE=00:
  - AS20 low for exactly 2 cycles.
  - ACK after edge k+4 with RDATA=0xDEADBEEF and ERR=0.
  - SIZ=00, RW20=1 throughout.
- Write byte to 0x00E90001, WDATA=0x5A000000, DTACK low after 3 WAIT cycles:
  - DS20 falls one cycle after AS20.
  - D_OE=1 from ADDR through END.
  - ACK arrives 1 cycle after DLATCH.
  - RW20=0, SIZ=01.
- BERR and STERM low on the same WAIT edge: ERR=1 with ACK, and RDATA is unchanged.
- TIMEOUT=4, no termination: ACK with ERR=1 after 5 WAIT edges. AS20/DS20 return high in END.
- RESET low during WAIT: the next edge gives AS20=DS20=1, BUSY=0, D_OE=0 and no ACK. A REQ after release starts cleanly.
- REQ held high for 3 cycles:
  - Three complete cycles with 3 ACK pulses.
  - AS20 high for 2 cycles between each.
  - BUSY low for exactly one cycle (IDLE) between each.

Source files
------------

// File: rtl/cpu_bus_master.sv
// cpu_bus_master: 68030-style synchronous bus initiator.
// Turns a one-shot REQ into a full AS20/DS20/RW20/SIZ bus cycle that ends on
// STERM, DTACK (plus one synchronising cycle) or BERR, with an optional
// WAIT-state timeout that forces an error termination.
module cpu_bus_master #(
  parameter int unsigned TIMEOUT = 255  // WAIT edges before forced error; 0 disables
) (
  input  logic        CLKCPU,
  input  logic        RESET,
  input  logic        REQ,
  input  logic        WE,
  input  logic [31:0] ADDR,
  input  logic [1:0]  SIZE,
  input  logic [31:0] WDATA,
  output logic [31:0] RDATA,
  output logic        ACK,
  output logic        ERR,
  output logic        BUSY,
  output logic [31:0] A,
  output logic [1:0]  SIZ,
  output logic        RW20,
  output logic        AS20,
  output logic        DS20,
  output logic [31:0] D_OUT,
  output logic        D_OE,
  input  logic [31:0] D_IN,
  input  logic        STERM,
  input  logic        DTACK,
  input  logic        BERR
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_STROBE,
    S_WAIT,
    S_DLATCH,
    S_END
  } state_t;

  localparam logic [7:0] TIMEOUT_VAL = 8'(TIMEOUT);
  localparam logic       TIMEOUT_EN  = (TIMEOUT != 0);

  state_t      state;
  state_t      next_state;
  logic [7:0]  cnt;
  logic        we_q;
  logic [31:0] wdata_q;
  logic        timeout_hit;

  assign timeout_hit = TIMEOUT_EN && (cnt == TIMEOUT_VAL);

  // State register.
  always_ff @(posedge CLKCPU) begin
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // the pre-edge values; blocking here would create order-dependent races.
    if (!RESET) state <= S_IDLE;
    else        state <= next_state;
  end

  // Next-state decode; termination inputs only matter in WAIT.
  always_comb begin
    // NOTE: default first so every path assigns next_state and no latch is inferred.
    next_state = state;
    unique case (state)
      S_IDLE:   if (REQ) next_state = S_ADDR;
      S_ADDR:   next_state = S_STROBE;
      S_STROBE: next_state = S_WAIT;
      S_WAIT: begin
        if (!BERR || !STERM) next_state = S_END;
        else if (!DTACK)     next_state = S_DLATCH;
        else if (timeout_hit) next_state = S_END;
      end
      S_DLATCH: next_state = S_END;
      S_END:    next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
  end

  // Registered bus and handshake outputs, updated by the state being left.
  always_ff @(posedge CLKCPU) begin
    if (!RESET) begin
      A       <= '0;
      SIZ     <= 2'b00;
      RW20    <= 1'b1;
      AS20    <= 1'b1;
      DS20    <= 1'b1;
      D_OUT   <= '0;
      D_OE    <= 1'b0;
      RDATA   <= '0;
      ACK     <= 1'b0;
      ERR     <= 1'b0;
      BUSY    <= 1'b0;
      cnt     <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          ACK  <= 1'b0;
          ERR  <= 1'b0;
          D_OE <= 1'b0;
          if (REQ) begin
            A       <= ADDR;
            SIZ     <= SIZE;
            RW20    <= ~WE;
            we_q    <= WE;
            wdata_q <= WDATA;
            BUSY    <= 1'b1;
          end
        end
        S_ADDR: begin
          AS20 <= 1'b1;
          DS20 <= 1'b1;
          if (we_q) begin
            D_OUT <= wdata_q;
            D_OE  <= 1'b1;
          end
        end
        S_STROBE: begin
          AS20 <= 1'b0;
          DS20 <= we_q;   // reads strobe data with AS20, writes one cycle later
          cnt  <= '0;
        end
        S_WAIT: begin
          AS20 <= 1'b0;
          DS20 <= 1'b0;
          if (!BERR) begin
            ERR <= 1'b1;
          end else if (!STERM) begin
            if (!we_q) RDATA <= D_IN;
          end else if (!DTACK) begin
            // data is taken in DLATCH, after one synchronising cycle
          end else if (timeout_hit) begin
            ERR <= 1'b1;
          end else if (cnt != 8'hFF) begin
            cnt <= cnt + 8'd1;
          end
        end
        S_DLATCH: begin
          if (!we_q) RDATA <= D_IN;
        end
        S_END: begin
          AS20 <= 1'b1;
          DS20 <= 1'b1;
          ACK  <= 1'b1;
          BUSY <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_bus_master.sv
// tb_cpu_bus_master: randomized self-checking bench for cpu_bus_master.
// A transaction-level model predicts, from the termination kind and the WAIT
// edge on which it arrives, when ACK appears, how long the strobes and data
// enable are active, and what RDATA/ERR must be.
module tb_cpu_bus_master;

  localparam int TO = 4;

  // termination kinds
  localparam int K_STERM   = 0;
  localparam int K_DTACK   = 1;
  localparam int K_BERR    = 2;
  localparam int K_BOTH    = 3;  // BERR and STERM on the same edge
  localparam int K_TIMEOUT = 4;

  logic        CLKCPU = 1'b0;
  logic        RESET  = 1'b0;
  logic        REQ    = 1'b0;
  logic        WE     = 1'b0;
  logic [31:0] ADDR   = '0;
  logic [1:0]  SIZE   = '0;
  logic [31:0] WDATA  = '0;
  logic [31:0] RDATA;
  logic        ACK, ERR, BUSY;
  logic [31:0] A;
  logic [1:0]  SIZ;
  logic        RW20, AS20, DS20;
  logic [31:0] D_OUT;
  logic        D_OE;
  logic [31:0] D_IN  = '0;
  logic        STERM = 1'b1;
  logic        DTACK = 1'b1;
  logic        BERR  = 1'b1;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] model_rdata = '0;

  always #5 CLKCPU = ~CLKCPU;

  cpu_bus_master #(.TIMEOUT(TO)) dut (
    .CLKCPU(CLKCPU), .RESET(RESET), .REQ(REQ), .WE(WE), .ADDR(ADDR),
    .SIZE(SIZE), .WDATA(WDATA), .RDATA(RDATA), .ACK(ACK), .ERR(ERR),
    .BUSY(BUSY), .A(A), .SIZ(SIZ), .RW20(RW20), .AS20(AS20), .DS20(DS20),
    .D_OUT(D_OUT), .D_OE(D_OE), .D_IN(D_IN), .STERM(STERM), .DTACK(DTACK),
    .BERR(BERR)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One bus cycle. Inputs change and outputs are sampled on the falling edge;
  // sample index e means "just after rising edge k+e", k being the REQ edge.
  // The chosen termination is asserted for exactly the w-th WAIT edge.
  task automatic run_txn(input string name, input logic we, input logic [31:0] addr,
                         input logic [1:0] size, input logic [31:0] wdata,
                         input logic [31:0] din, input int kind, input int w);
    int  dl      = (kind == K_DTACK) ? 1 : 0;
    int  ack_e   = 3 + w + dl;
    int  term_e  = 2 + w;
    bit  err_exp = (kind >= K_BERR);
    int  first_ack = -1, n_ack = 0, as_low = 0, ds_low = 0, ds_fall = -1;
    int  oe_high = 0, busy_high = 0, addr_bad = 0;
    logic [31:0] rdata_at_ack = '0, dout_at_ack = '0;
    logic err_at_ack = 1'b0, err_after = 1'b1, oe_after = 1'b1;

    if (!we && (kind == K_STERM || kind == K_DTACK)) model_rdata = din;

    @(negedge CLKCPU);
    REQ = 1'b1; WE = we; ADDR = addr; SIZE = size; WDATA = wdata; D_IN = din;
    @(negedge CLKCPU);
    REQ = 1'b0;
    for (int e = 0; e <= ack_e + 1; e++) begin
      if (ACK) begin
        n_ack++;
        if (first_ack < 0) begin
          first_ack    = e;
          rdata_at_ack = RDATA;
          dout_at_ack  = D_OUT;
          err_at_ack   = ERR;
        end
      end
      if (!AS20) as_low++;
      if (!DS20) begin
        ds_low++;
        if (ds_fall < 0) ds_fall = e;
      end
      if (D_OE) oe_high++;
      if (BUSY) busy_high++;
      if (e <= ack_e && (A !== addr || SIZ !== size || RW20 !== ~we)) addr_bad++;
      if (e == ack_e + 1) begin
        err_after = ERR;
        oe_after  = D_OE;
      end
      STERM = !((kind == K_STERM || kind == K_BOTH) && (e + 1 == term_e));
      BERR  = !((kind == K_BERR  || kind == K_BOTH) && (e + 1 == term_e));
      DTACK = !((kind == K_DTACK) && (e + 1 == term_e));
      @(negedge CLKCPU);
    end
    STERM = 1'b1; BERR = 1'b1; DTACK = 1'b1;

    check({name, "_ack_edge"},  32'(first_ack), 32'(ack_e));
    check({name, "_ack_count"}, 32'(n_ack), 32'd1);
    check({name, "_err"},       32'(err_at_ack), 32'(err_exp));
    check({name, "_rdata"},     rdata_at_ack, model_rdata);
    check({name, "_as_low"},    32'(as_low), 32'(w + dl + 1));
    check({name, "_ds_low"},    32'(ds_low), 32'(we ? w + dl : w + dl + 1));
    check({name, "_ds_fall"},   32'(ds_fall), 32'(we ? 3 : 2));
    check({name, "_doe_high"},  32'(oe_high), 32'(we ? 3 + w + dl : 0));
    check({name, "_busy_high"}, 32'(busy_high), 32'(ack_e));
    check({name, "_addr_stable"}, 32'(addr_bad), 32'd0);
    check({name, "_idle_clear"}, {30'd0, err_after, oe_after}, 32'd0);
    if (we) check({name, "_dout"}, dout_at_ack, wdata);
  endtask

  // Mid-cycle reset: abort in WAIT, then confirm no ACK leaks out.
  task automatic reset_abort();
    int n_ack = 0;
    @(negedge CLKCPU);
    REQ = 1'b1; WE = 1'b1; ADDR = 32'h0000_1000; SIZE = 2'b10; WDATA = 32'hCAFE_F00D;
    @(negedge CLKCPU);                       // after edge k
    REQ = 1'b0;
    repeat (3) @(negedge CLKCPU);            // after k+3: first WAIT edge done
    RESET = 1'b0;
    @(negedge CLKCPU);
    check("rst_mid_as20", 32'(AS20), 32'd1);
    check("rst_mid_ds20", 32'(DS20), 32'd1);
    check("rst_mid_busy", 32'(BUSY), 32'd0);
    check("rst_mid_doe",  32'(D_OE), 32'd0);
    check("rst_mid_ack",  32'(ACK),  32'd0);
    RESET = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (ACK) n_ack++;
      @(negedge CLKCPU);
    end
    check("rst_mid_no_ack", 32'(n_ack), 32'd0);
  endtask

  // REQ held high: three back-to-back reads, each STERM-terminated in one WAIT.
  task automatic back_to_back();
    int acks[$];
    int busy_low = 0, min_gap = 99, run = 0;
    bit seen_low = 1'b0;
    logic [31:0] din = 32'h1357_9BDF;
    @(negedge CLKCPU);
    REQ = 1'b1; WE = 1'b0; ADDR = 32'h00F0_0000; SIZE = 2'b00; D_IN = din; STERM = 1'b0;
    @(negedge CLKCPU);
    for (int e = 0; e <= 16; e++) begin
      if (ACK) acks.push_back(e);
      if (e <= 13 && !BUSY) busy_low++;
      if (AS20) run++;
      else begin
        if (seen_low && run > 0 && run < min_gap) min_gap = run;
        seen_low = 1'b1;
        run = 0;
      end
      if (e == 10) REQ = 1'b0;              // third cycle accepted on edge k+10
      @(negedge CLKCPU);
    end
    STERM = 1'b1;
    model_rdata = din;
    check("b2b_ack_count", 32'(acks.size()), 32'd3);
    for (int i = 0; i < acks.size() && i < 3; i++)
      check("b2b_ack_edge", 32'(acks[i]), 32'(4 + 5 * i));
    check("b2b_busy_low", 32'(busy_low), 32'd2);
    check("b2b_as_gap_ge2", 32'(min_gap >= 2 && min_gap != 99), 32'd1);
    check("b2b_rdata", RDATA, model_rdata);
  endtask

  initial begin
    RESET = 1'b0;
    repeat (3) @(negedge CLKCPU);
    check("rst_a",     A, 32'd0);
    check("rst_siz",   32'(SIZ), 32'd0);
    check("rst_rw20",  32'(RW20), 32'd1);
    check("rst_as20",  32'(AS20), 32'd1);
    check("rst_ds20",  32'(DS20), 32'd1);
    check("rst_dout",  D_OUT, 32'd0);
    check("rst_doe",   32'(D_OE), 32'd0);
    check("rst_rdata", RDATA, 32'd0);
    check("rst_ack",   32'(ACK), 32'd0);
    check("rst_err",   32'(ERR), 32'd0);
    check("rst_busy",  32'(BUSY), 32'd0);
    RESET = 1'b1;
    @(negedge CLKCPU);

    run_txn("rd_sterm", 1'b0, 32'h0020_0004, 2'b00, 32'h0, 32'hDEAD_BEEF, K_STERM, 1);
    run_txn("wr_dtack", 1'b1, 32'h00E9_0001, 2'b01, 32'h5A00_0000, 32'h1111_1111, K_DTACK, 4);
    run_txn("rd_both",  1'b0, 32'h0000_0040, 2'b10, 32'h0, 32'h2222_2222, K_BOTH, 2);
    run_txn("rd_tmo",   1'b0, 32'h00DA_0000, 2'b00, 32'h0, 32'h3333_3333, K_TIMEOUT, TO + 1);
    reset_abort();
    run_txn("rd_post_rst", 1'b0, 32'h0020_0008, 2'b11, 32'h0, 32'h4444_4444, K_DTACK, 1);
    back_to_back();

    for (int i = 0; i < 24; i++) begin
      logic        we   = 1'($urandom_range(0, 1));
      int          kind = $urandom_range(0, 4);
      int          w    = (kind == K_TIMEOUT) ? TO + 1 : $urandom_range(1, TO + 1);
      logic [31:0] addr = $urandom;
      logic [1:0]  size = 2'($urandom_range(0, 3));
      logic [31:0] wd   = $urandom;
      logic [31:0] din  = $urandom;
      run_txn("rand", we, addr, size, wd, din, kind, w);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
